// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer: FSM encodings,
// the per-stage control bundle and the exception vector used by the PC mux.
package pipeline_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_FREEZE  = 2'd1,
    ST_RECOVER = 2'd2
  } state_t;

  localparam logic [31:0] EXC_VECTOR = 32'h0000_0080;

  // Bit order matches the top-level port order, MSB first.
  typedef struct packed {
    logic pc_write;
    logic pc_sel_handler;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_write;
    logic id_ex_flush;
    logic ex_mem_write;
    logic ex_mem_flush;
  } stage_ctrl_t;

  localparam stage_ctrl_t CTRL_IDLE = '0;
  localparam stage_ctrl_t CTRL_FLOW = '{
    pc_write: 1'b1, pc_sel_handler: 1'b0,
    if_id_write: 1'b1, if_id_flush: 1'b0,
    id_ex_write: 1'b1, id_ex_flush: 1'b0,
    ex_mem_write: 1'b1, ex_mem_flush: 1'b0
  };

  function automatic logic any_flush(input stage_ctrl_t c);
    return c.if_id_flush | c.id_ex_flush | c.ex_mem_flush;
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter used for the stall/flush performance counters.
// Holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q <= '0;
    end else if (inc && (r_q != '1)) begin
      r_q <= r_q + W'(1);
    end
  end

  assign q = r_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline: merges hazard
// sources into per-stage write/flush controls and bounds memory freezes.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int TMO_W          = 5,
  parameter int CNT_W          = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_LW_Stall,
  input  logic             i_Jump_ID,
  input  logic             i_Branch_EX_Taken,
  input  logic             i_Mem_Busy,
  output logic             o_PC_Write,
  output logic             o_PC_Sel_Handler,
  output logic             o_IF_ID_Write,
  output logic             o_IF_ID_Flush,
  output logic             o_ID_EX_Write,
  output logic             o_ID_EX_Flush,
  output logic             o_EX_MEM_Write,
  output logic             o_EX_MEM_Flush,
  output logic             o_Timeout,
  output logic [CNT_W-1:0] o_Stall_Cnt,
  output logic [CNT_W-1:0] o_Flush_Cnt
);

  state_t           r_state;
  state_t           w_state_next;
  logic [TMO_W-1:0] r_freeze_cnt;
  logic [TMO_W-1:0] w_freeze_cnt_next;
  logic             r_timeout;
  logic             w_timeout_next;
  stage_ctrl_t      w_ctrl;
  stage_ctrl_t      w_ctrl_out;
  logic             w_stall_inc;
  logic             w_flush_inc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_RUN;
      r_freeze_cnt <= '0;
      r_timeout    <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_freeze_cnt <= w_freeze_cnt_next;
      r_timeout    <= w_timeout_next;
    end
  end

  always_comb begin
    w_ctrl            = CTRL_IDLE;
    w_state_next      = r_state;
    w_freeze_cnt_next = r_freeze_cnt;
    w_timeout_next    = 1'b0;
    unique case (r_state)
      ST_RUN: begin
        if (i_Mem_Busy) begin
          w_state_next      = ST_FREEZE;
          w_freeze_cnt_next = TMO_W'(1);
        end else if (i_Branch_EX_Taken) begin
          // Load-use and jump in younger stages are on the wrong path.
          w_ctrl             = CTRL_FLOW;
          w_ctrl.if_id_flush = 1'b1;
          w_ctrl.id_ex_flush = 1'b1;
        end else if (i_LW_Stall) begin
          w_ctrl             = CTRL_FLOW;
          w_ctrl.pc_write    = 1'b0;
          w_ctrl.if_id_write = 1'b0;
          w_ctrl.id_ex_flush = 1'b1;
        end else if (i_Jump_ID) begin
          w_ctrl             = CTRL_FLOW;
          w_ctrl.if_id_flush = 1'b1;
        end else begin
          w_ctrl = CTRL_FLOW;
        end
      end
      ST_FREEZE: begin
        // Exit cycle stays frozen; held stage inputs are re-evaluated in RUN.
        if (!i_Mem_Busy) begin
          w_state_next      = ST_RUN;
          w_freeze_cnt_next = '0;
        end else if (r_freeze_cnt == TMO_W'(TIMEOUT_CYCLES)) begin
          w_state_next      = ST_RECOVER;
          w_freeze_cnt_next = '0;
          w_timeout_next    = 1'b1;
        end else begin
          w_freeze_cnt_next = r_freeze_cnt + TMO_W'(1);
        end
      end
      ST_RECOVER: begin
        w_ctrl                = CTRL_FLOW;
        w_ctrl.pc_sel_handler = 1'b1;
        w_ctrl.if_id_flush    = 1'b1;
        w_ctrl.id_ex_flush    = 1'b1;
        w_ctrl.ex_mem_flush   = 1'b1;
        w_state_next          = ST_RUN;
      end
      default: begin
        w_state_next      = ST_RUN;
        w_freeze_cnt_next = '0;
      end
    endcase
  end

  assign w_ctrl_out = reset ? CTRL_IDLE : w_ctrl;

  assign o_PC_Write       = w_ctrl_out.pc_write;
  assign o_PC_Sel_Handler = w_ctrl_out.pc_sel_handler;
  assign o_IF_ID_Write    = w_ctrl_out.if_id_write;
  assign o_IF_ID_Flush    = w_ctrl_out.if_id_flush;
  assign o_ID_EX_Write    = w_ctrl_out.id_ex_write;
  assign o_ID_EX_Flush    = w_ctrl_out.id_ex_flush;
  assign o_EX_MEM_Write   = w_ctrl_out.ex_mem_write;
  assign o_EX_MEM_Flush   = w_ctrl_out.ex_mem_flush;
  assign o_Timeout        = r_timeout;

  assign w_stall_inc = !w_ctrl_out.pc_write &&
                       ((r_state == ST_RUN) || (r_state == ST_FREEZE));
  assign w_flush_inc = any_flush(w_ctrl_out);

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (w_stall_inc),
    .q     (o_Stall_Cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (w_flush_inc),
    .q     (o_Flush_Cnt)
  );

endmodule
